// File: rtl/move_scanner_if.sv
// Select/move-word bundle between the scanner, the external move mux and the downstream consumer.
interface move_scanner_if #(
  parameter int unsigned SQ_W   = 6,
  parameter int unsigned DIR_W  = 4,
  parameter int unsigned MOVE_W = 32
);
  logic [SQ_W-1:0]   sel_square;
  logic [DIR_W-1:0]  sel_dir;
  logic [MOVE_W-1:0] move_in;
  logic [MOVE_W-1:0] move_out;
  logic              move_valid;
  logic              move_ready;

  modport master (
    output sel_square, sel_dir, move_out, move_valid,
    input  move_in, move_ready
  );

  modport slave (
    input  sel_square, sel_dir, move_out, move_valid,
    output move_in, move_ready
  );
endinterface

// File: rtl/move_scanner.sv
// Sweeps every (square, direction) move slot, drops empty/non-capture words and
// streams the survivors on a valid/ready port with a saturating move counter.
module move_scanner #(
  parameter int unsigned NUM_SQ  = 64,
  parameter int unsigned NUM_DIR = 16,
  parameter int unsigned MOVE_W  = 32,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              abort,
  input  logic              capture_only,
  move_scanner_if.master    mv,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  move_count,
  output logic              overflow
);

  localparam int unsigned SQ_W    = $clog2(NUM_SQ);
  localparam int unsigned DIR_W   = $clog2(NUM_DIR);
  localparam int unsigned CAP_LSB = 24;
  localparam int unsigned CAP_MSB = 29;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [SQ_W-1:0]  SQ_LAST  = SQ_W'(NUM_SQ - 1);
  localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(NUM_DIR - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SQ_W-1:0]    sel_sq_q, sel_sq_d;
  logic [DIR_W-1:0]   sel_dir_q, sel_dir_d;
  logic [MOVE_W-1:0]  out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               cap_q, cap_d;

  logic eligible_c;
  logic slot_free_c;
  logic handshake_c;
  logic last_slot_c;

  assign eligible_c  = (mv.move_in != '0) &&
                       (!cap_q || (mv.move_in[CAP_MSB:CAP_LSB] != '0));
  assign slot_free_c = !valid_q || mv.move_ready;
  assign handshake_c = valid_q && mv.move_ready;
  assign last_slot_c = (sel_sq_q == SQ_LAST) && (sel_dir_q == DIR_LAST);

  // Next-state and next-output logic; every register defaults to hold.
  always_comb begin
    state_d   = state_q;
    sel_sq_d  = sel_sq_q;
    sel_dir_d = sel_dir_q;
    out_d     = out_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    cap_d     = cap_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          sel_sq_d  = '0;
          sel_dir_d = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          cap_d     = capture_only;
          busy_d    = 1'b1;
        end
      end

      SCAN: begin
        if (abort) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          sel_sq_d  = '0;
          sel_dir_d = '0;
          busy_d    = 1'b0;
        end else begin
          if (handshake_c) valid_d = 1'b0;
          // An eligible word with a full output slot stalls the sweep in place.
          if (!eligible_c || slot_free_c) begin
            if (eligible_c) begin
              out_d   = mv.move_in;
              valid_d = 1'b1;
              if (cnt_q == CNT_MAX) ovf_d = 1'b1;
              else                  cnt_d = CNT_W'(cnt_q + 1'b1);
            end
            if (last_slot_c) begin
              state_d   = DRAIN;
              sel_sq_d  = '0;
              sel_dir_d = '0;
            end else if (sel_dir_q == DIR_LAST) begin
              sel_dir_d = '0;
              sel_sq_d  = SQ_W'(sel_sq_q + 1'b1);
            end else begin
              sel_dir_d = DIR_W'(sel_dir_q + 1'b1);
            end
          end
        end
      end

      DRAIN: begin
        if (abort) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          sel_sq_d  = '0;
          sel_dir_d = '0;
          busy_d    = 1'b0;
        end else if (slot_free_c) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        valid_d   = 1'b0;
        sel_sq_d  = '0;
        sel_dir_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      sel_sq_q  <= '0;
      sel_dir_q <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_sq_q  <= sel_sq_d;
      sel_dir_q <= sel_dir_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      cap_q     <= cap_d;
    end
  end

  assign mv.sel_square = sel_sq_q;
  assign mv.sel_dir    = sel_dir_q;
  assign mv.move_out   = out_q;
  assign mv.move_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign move_count    = cnt_q;
  assign overflow      = ovf_q;

endmodule

// File: doc/move_scanner.md
Name: move_scanner

Overview:
- Sequencer that sweeps the 64-square x 16-direction move outputs of the square array.
- Drives a registered (square, direction) select to an external combinational mux.
- Filters out empty, and optionally non-capture, move words.
- Serializes the surviving 32-bit move words onto a valid/ready stream for the search/evaluation stage, counting moves and flagging overflow.

Parameters:
- NUM_SQ, 64, squares scanned; select width 6.
- NUM_DIR, 16, move slots per square (8 sliding + 8 knight); select width 4.
- MOVE_W, 32, move word width.
- CNT_W, 8, move counter width; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- clear  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a scan; ignored unless idle.
- abort  in  1  cancels a scan in progress.
- capture_only  in  1  when 1, only moves with nonzero captured-piece field [29:24] are emitted; latched at start.
- sel_square  out  6  square index driven to the move mux.
- sel_dir  out  4  direction slot driven to the move mux.
- move_in  in  MOVE_W  move word for the current select; combinational from the mux, sampled the same cycle.
- move_out  out  MOVE_W  registered move word.
- move_valid  out  1  move_out holds an unconsumed move.
- move_ready  in  1  downstream accepts move_out when move_valid && move_ready.
- busy  out  1  high in SCAN or DRAIN.
- done  out  1  one-cycle pulse at scan completion.
- move_count  out  CNT_W  moves emitted this scan; saturating.
- overflow  out  1  sticky; set when a move is emitted with move_count already at max.

Behaviour:
- Reset (clear=1 at posedge): state IDLE, sel_square=0, sel_dir=0, move_out=0, move_valid=0, busy=0, done=0, move_count=0, overflow=0.
- clear has priority over all other inputs.
- State IDLE:
  - start=1 -> SCAN; sel=(0,0); move_count=0; overflow=0; latch capture_only.
  - move_out and move_valid keep their values.
- Scan order: sel_dir increments fastest (0..15), then sel_square (0..63). Last index is (63,15).
- State SCAN, per cycle:
  - The slot is eligible if move_in!=0 and (!capture_only_latched or move_in[29:24]!=0).
  - slot_free = !move_valid || move_ready.
  - If the slot is ineligible: advance the index regardless of slot_free.
  - If the slot is eligible and slot_free: load move_out=move_in, move_valid=1, move_count += 1 (saturate; set overflow if already max), advance.
  - If the slot is eligible and !slot_free: stall; select holds, move_in is re-sampled next cycle.
  - Advancing from (63,15) -> DRAIN. sel returns to (0,0).
- With no stalls, one slot is processed per cycle: a full scan is 1024 SCAN cycles.
- move_valid clears on handshake unless a new move loads the same cycle.
- Handshake: move_out is stable while move_valid && !move_ready. move_valid never drops without a handshake except on abort or clear.
- State DRAIN:
  - Wait until move_valid=0, or a handshake occurs this cycle.
  - Then go to IDLE with done=1 for exactly the following cycle.
  - If move_valid is already 0 on entry, done fires the cycle after entry.
- busy=1 in SCAN and DRAIN only.
- abort=1 in SCAN or DRAIN -> IDLE next cycle: move_valid=0, sel=(0,0), no done pulse; move_count and overflow hold.
- abort in IDLE has no effect. Simultaneous start+abort in IDLE: start wins.
- start while busy is ignored; no restart.
- move_count and overflow hold after done until the next start.

Test Plan:
- Empty board: all move_in=0, move_ready=1, start at cycle 0 -> sel sweeps 1024 cycles; no move_valid; done pulses once at cycle 1026; move_count=0.
- Sparse moves: move_in nonzero only at (12,3)=32'h0001_0C13 and (63,15)=32'h0A3F_2008, ready=1 -> exactly these two words emitted in that order; move_count=2; done 1 cycle after the last handshake.
- Backpressure: move_ready=0 for 5 cycles while 3 consecutive eligible slots are pending -> select frozen at the 2nd slot; move_out stable; no word lost or duplicated; all 3 delivered.
- capture_only=1 at start, toggled to 0 mid-scan -> only words with [29:24]!=0 emitted, e.g. 32'h0412_0910 emitted, 32'h0012_0910 skipped.
- Overflow: all 1024 slots nonzero, ready=1 -> move_count=255, overflow=1 at done.
- abort at cycle 100 with move_valid=1 and ready=0 -> move_valid=0 next cycle; busy=0; no done. A subsequent start resets move_count to 0.
